virtual_input_ctrl: RTL and testbench

Clocked, parametrised successor to the virtual-input command decoder for the DE2-115 virtual board. It receives a command code plus an asynchronous command strobe from the host link, and drives NUM_BTN momentary virtual buttons and NUM_SW toggle virtual switches. The strobe is synchronised and debounced, and each command executes exactly once. Buttons run in level or timed-pulse mode, and each command returns an ack or error pulse to the link logic.

---
 rtl/virtual_input_ctrl.sv | 177 +++++++++++++++++
 tb/tb_virtual_input_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/virtual_input_ctrl.sv
// Virtual push-button / toggle-switch command decoder for the DE2-115 virtual board.
// A synchronised, debounced host strobe executes one command code per strobe.
module virtual_input_ctrl #(
  parameter int NUM_BTN  = 4,
  parameter int NUM_SW   = 18,
  parameter int CMD_W    = 5,
  parameter int BTN_MODE = 1,
  parameter int BTN_HOLD = 2500000,
  parameter int DEB_CYC  = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [CMD_W-1:0]   number,
  input  logic               control,
  output logic [NUM_BTN-1:0] buttons,
  output logic [NUM_SW-1:0]  switches,
  output logic               cmd_ack,
  output logic               cmd_err
);

  localparam int               DEB_W    = $clog2(DEB_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYC);
  localparam logic [CMD_W-1:0] CLR_CODE = {CMD_W{1'b1}};
  localparam logic [CMD_W-1:0] CODE_LIM = CMD_W'(NUM_BTN + NUM_SW);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  function automatic logic [DEB_W-1:0] sat_inc(input logic [DEB_W-1:0] v);
    return (v == DEB_MAX) ? v : v + DEB_W'(1);
  endfunction

  logic               sync1_q;
  logic               ctl_s_q;
  state_t             state_q, state_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [DEB_W-1:0]   low_cnt_q, low_cnt_d;
  logic [DEB_W-1:0]   low_inc;
  logic [NUM_SW-1:0]  switches_q, switches_d;
  logic               cmd_ack_q, cmd_ack_d;
  logic               cmd_err_q, cmd_err_d;
  logic [NUM_BTN-1:0] press;
  logic               clr_lvl;
  logic               code_valid;

  // Two-flop synchroniser for the asynchronous host strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      ctl_s_q <= 1'b0;
    end else begin
      sync1_q <= control;
      ctl_s_q <= sync1_q;
    end
  end

  assign code_valid = (cmd_q < CODE_LIM) || (cmd_q == CLR_CODE);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    low_cnt_d  = low_cnt_q;
    switches_d = switches_q;
    cmd_ack_d  = 1'b0;
    cmd_err_d  = 1'b0;
    press      = '0;
    clr_lvl    = 1'b0;
    low_inc    = sat_inc(low_cnt_q);
    case (state_q)
      IDLE: begin
        if (ctl_s_q) begin
          state_d = EXEC;
          cmd_d   = number;
        end
      end
      EXEC: begin
        state_d   = WAIT_LOW;
        low_cnt_d = '0;
        cmd_ack_d = code_valid;
        cmd_err_d = ~code_valid;
        for (int i = 0; i < NUM_BTN; i++) begin
          if (cmd_q == CMD_W'(NUM_BTN - 1 - i)) press[i] = 1'b1;
        end
        for (int j = 0; j < NUM_SW; j++) begin
          if (cmd_q == CMD_W'(NUM_BTN + NUM_SW - 1 - j)) switches_d[j] = ~switches_q[j];
        end
        if (cmd_q == CLR_CODE) switches_d = '0;
      end
      WAIT_LOW: begin
        // Any high sample restarts the low run; only an unbroken run re-arms
        clr_lvl = ~ctl_s_q;
        if (ctl_s_q) begin
          low_cnt_d = '0;
        end else if (low_inc == DEB_MAX) begin
          state_d   = IDLE;
          low_cnt_d = '0;
        end else begin
          low_cnt_d = low_inc;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_LOW;
      cmd_q      <= '0;
      low_cnt_q  <= '0;
      switches_q <= '0;
      cmd_ack_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      low_cnt_q  <= low_cnt_d;
      switches_q <= switches_d;
      cmd_ack_q  <= cmd_ack_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign switches = switches_q;
  assign cmd_ack  = cmd_ack_q;
  assign cmd_err  = cmd_err_q;

  if (BTN_MODE == 0) begin : g_level
    logic [NUM_BTN-1:0] btn_q, btn_d;

    always_comb begin
      btn_d = btn_q;
      if (|press)       btn_d = press;
      else if (clr_lvl) btn_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) btn_q <= '0;
      else          btn_q <= btn_d;
    end

    assign buttons = btn_q;
  end else begin : g_pulse
    localparam int                HOLD_W    = $clog2(BTN_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(BTN_HOLD);

    function automatic logic [HOLD_W-1:0] sat_dec(input logic [HOLD_W-1:0] v);
      return (v == '0) ? v : v - HOLD_W'(1);
    endfunction

    logic [HOLD_W-1:0] hold_q [NUM_BTN];
    logic [HOLD_W-1:0] hold_d [NUM_BTN];

    // A re-press reloads instead of decrementing, so an active button never drops
    always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
        hold_d[i] = press[i] ? HOLD_LOAD : sat_dec(hold_q[i]);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= '0;
      end else begin
        for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= hold_d[i];
      end
    end

    always_comb begin
      buttons = '0;
      for (int i = 0; i < NUM_BTN; i++) buttons[i] = (hold_q[i] != '0);
    end
  end

endmodule

// File: tb/tb_virtual_input_ctrl.sv
// Bench for virtual_input_ctrl: a timed-pulse and a level-mode instance share one
// stimulus stream and are checked against an event-level reference model.
module tb_virtual_input_ctrl;

  localparam int NB   = 4;
  localparam int NS   = 18;
  localparam int HOLD = 8;
  localparam int DEB  = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4:0]    number;
  logic          control;
  logic [NB-1:0] b0, b1;
  logic [NS-1:0] sw0, sw1;
  logic          ack0, err0, ack1, err1;

  virtual_input_ctrl #(
    .NUM_BTN(NB), .NUM_SW(NS), .CMD_W(5), .BTN_MODE(1), .BTN_HOLD(HOLD), .DEB_CYC(DEB)
  ) dut_pulse (
    .clk(clk), .reset_n(reset_n), .number(number), .control(control),
    .buttons(b0), .switches(sw0), .cmd_ack(ack0), .cmd_err(err0)
  );

  virtual_input_ctrl #(
    .NUM_BTN(NB), .NUM_SW(NS), .CMD_W(5), .BTN_MODE(0), .BTN_HOLD(HOLD), .DEB_CYC(DEB)
  ) dut_level (
    .clk(clk), .reset_n(reset_n), .number(number), .control(control),
    .buttons(b1), .switches(sw1), .cmd_ack(ack1), .cmd_err(err1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: strobe seen two edges late; one command per armed strobe
  typedef struct { int due; bit ack; bit err; } resp_t;
  resp_t         sb_q[$];
  int            m_cyc;
  int            m_exp [NB];
  int            m_lvl;
  int            m_run;
  bit            m_armed, m_pending;
  logic [4:0]    m_code;
  logic [NS-1:0] m_sw;
  logic          m_s1, m_s2, m_seen;

  initial begin
    m_cyc = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_s1 = 0; m_s2 = 0; m_armed = 0; m_pending = 0; m_run = 0;
        m_sw = '0; m_lvl = -1; m_code = '0;
        for (int i = 0; i < NB; i++) m_exp[i] = 0;
        sb_q.delete();
      end else begin
        m_cyc++;
        m_seen = m_s2; m_s2 = m_s1; m_s1 = control;
        if (m_pending) begin
          automatic int c = int'(m_code);
          automatic resp_t r;
          r.due = m_cyc; r.ack = 1; r.err = 0;
          if (c < NB) begin
            m_exp[NB-1-c] = m_cyc + HOLD;
            m_lvl = NB - 1 - c;
          end else if (c < NB + NS) begin
            m_sw[NS-1-(c-NB)] = ~m_sw[NS-1-(c-NB)];
          end else if (c == 31) begin
            m_sw = '0;
          end else begin
            r.ack = 0; r.err = 1;
          end
          sb_q.push_back(r);
          m_pending = 0; m_armed = 0; m_run = 0;
        end else if (m_armed) begin
          if (m_seen) begin
            m_pending = 1; m_armed = 0; m_code = number;
          end
        end else begin
          if (m_seen) m_run = 0;
          else begin
            m_lvl = -1;
            m_run++;
            if (m_run == DEB) begin m_armed = 1; m_run = 0; end
          end
        end
      end
    end
  end

  // Monitor: outputs every cycle, responses popped when due or when one appears
  int ack_seen = 0, err_seen = 0;
  initial begin
    forever begin
      @(negedge clk);
      begin
        automatic logic [NB-1:0] eb1 = '0;
        automatic logic [NB-1:0] eb0 = '0;
        for (int i = 0; i < NB; i++) eb1[i] = (m_cyc < m_exp[i]);
        if (m_lvl >= 0) eb0[m_lvl] = 1'b1;
        chk("buttons_pulse", 64'(b0), 64'(eb1));
        chk("buttons_level", 64'(b1), 64'(eb0));
        chk("switches_pulse", 64'(sw0), 64'(m_sw));
        chk("switches_level", 64'(sw1), 64'(m_sw));
        if (ack0) ack_seen++;
        if (err0) err_seen++;
        if (sb_q.size() > 0 && (sb_q[0].due <= m_cyc || ack0 || err0)) begin
          automatic resp_t r = sb_q.pop_front();
          chk("resp_cycle", 64'(m_cyc), 64'(r.due));
          chk("ack_pulse", 64'(ack0), 64'(r.ack));
          chk("err_pulse", 64'(err0), 64'(r.err));
          chk("ack_level", 64'(ack1), 64'(r.ack));
          chk("err_level", 64'(err1), 64'(r.err));
        end else begin
          chk("spurious_resp", 64'({ack0, err0, ack1, err1}), 64'(0));
        end
      end
    end
  end

  // Run-length of the last completed high interval of selected buttons
  int run3 = 0, last3 = 0, runl0 = 0, lastl0 = 0;
  always @(negedge clk) begin
    if (b0[3]) run3 = run3 + 1;
    else begin if (run3 != 0) last3 = run3; run3 = 0; end
    if (b1[0]) runl0 = runl0 + 1;
    else begin if (runl0 != 0) lastl0 = runl0; runl0 = 0; end
  end

  task automatic issue(input logic [4:0] code, input int hi, input int lo);
    @(negedge clk);
    number  = code;
    control = 1'b1;
    repeat (hi) @(negedge clk);
    control = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    int a0, e0;
    logic [NS-1:0] sv;
    reset_n = 1'b0;
    control = 1'b1;
    number  = 5'd4;
    repeat (4) @(negedge clk);
    chk("reset_buttons", 64'(b0), 64'(0));
    chk("reset_switches", 64'(sw0), 64'(0));
    chk("reset_ack_err", 64'({ack0, err0}), 64'(0));
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("held_strobe_not_run", 64'(ack_seen + err_seen), 64'(0));
    control = 1'b0;
    repeat (6) @(negedge clk);

    // Four-edge latency of a toggle
    a0 = ack_seen;
    @(negedge clk); number = 5'd4; control = 1'b1;
    @(negedge clk);
    @(negedge clk); control = 1'b0;
    @(negedge clk);
    chk("latency_pre", 64'(sw0), 64'(0));
    @(negedge clk);
    chk("latency_sw", 64'(sw0), 64'(18'h20000));
    chk("latency_ack", 64'(ack0), 64'(1));
    @(negedge clk);
    chk("ack_one_cycle", 64'(ack0), 64'(0));
    repeat (5) @(negedge clk);
    issue(5'd4, 2, 5);
    chk("toggle_back", 64'(sw0), 64'(0));
    chk("ack_count_t1", 64'(ack_seen - a0), 64'(2));

    // Pulse width and reload
    issue(5'd0, 1, 20);
    chk("pulse_width", 64'(last3), 64'(HOLD));
    issue(5'd0, 1, 3);
    issue(5'd0, 1, 20);
    chk("reload_width", 64'(last3), 64'(13));

    // Toggle sequence and clear-all
    a0 = ack_seen;
    issue(5'd4, 2, 5);  chk("seq_sw1", 64'(sw0), 64'(18'h20000));
    issue(5'd21, 2, 5); chk("seq_sw2", 64'(sw0), 64'(18'h20001));
    issue(5'd12, 2, 5); chk("seq_sw3", 64'(sw0), 64'(18'h20201));
    issue(5'd31, 2, 5); chk("clear_all", 64'(sw0), 64'(0));
    chk("ack_count_t3", 64'(ack_seen - a0), 64'(4));

    // Invalid code followed by a debounce glitch
    issue(5'd4, 2, 5);
    a0 = ack_seen; e0 = err_seen; sv = sw0;
    @(negedge clk); number = 5'd22; control = 1'b1;
    @(negedge clk);
    @(negedge clk); control = 1'b0;
    repeat (2) @(negedge clk);
    control = 1'b1;
    @(negedge clk); control = 1'b0;
    repeat (8) @(negedge clk);
    chk("invalid_err", 64'(err_seen - e0), 64'(1));
    chk("invalid_no_ack", 64'(ack_seen - a0), 64'(0));
    chk("invalid_sw_kept", 64'(sw0), 64'(sv));
    chk("invalid_btn_kept", 64'(b0), 64'(0));
    issue(5'd22, 2, 5);
    chk("rearmed_after_run", 64'(err_seen - e0), 64'(2));

    // Level mode: held while synced strobe high
    issue(5'd3, 10, 8);
    chk("level_width", 64'(lastl0), 64'(9));

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      issue(5'($urandom_range(0, 31)), int'($urandom_range(1, 4)), int'($urandom_range(0, 7)));
    end
    repeat (20) @(negedge clk);

    // Asynchronous reset during a pulse
    issue(5'd6, 1, 5);
    issue(5'd1, 1, 4);
    chk("pulse_active", 64'(b0[2]), 64'(1));
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("async_btn_pulse", 64'(b0), 64'(0));
    chk("async_sw_pulse", 64'(sw0), 64'(0));
    chk("async_btn_level", 64'(b1), 64'(0));
    chk("async_sw_level", 64'(sw1), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(5'd4, 2, 8);
    chk("after_reset_cmd", 64'(sw0), 64'(18'h20000));
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
